// File: rtl/spi_frame_rx_pkg.sv
// Shared types and constants for the SPI frame receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Frame-buffer write port plus frame status, driven by the receiver (master).
interface spi_frame_rx_if #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 54
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              frame_done;
  logic [ADDR_W:0]   frame_len;
  logic              overflow;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output frame_done,
    output frame_len,
    output overflow
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input frame_done,
    input frame_len,
    input overflow
  );

endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchronizer for an async pin with registered rise/fall pulses.
module sync_edge
  import spi_rx_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Edge outputs are registered, so pin-to-pulse latency is STAGES+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI-slave frame receiver: oversampled sck/sdi/load, word assembly into a
// frame buffer write port, frame status, and a one-word-delayed sdo echo.
module spi_frame_rx
  import spi_rx_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int DEPTH     = 54,
  parameter int LSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sck,
  input  logic           sdi,
  input  logic           load,
  output logic           sdo,
  spi_frame_rx_if.master wbus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BC_W   = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  logic sck_rise, sck_fall, load_rise, load_fall;

  logic [SYNC_STAGES:0] sdi_sync;
  logic                 sdi_s;

  rx_state_t state_q, state_d;
  logic      start, shift_en, word_end, frame_end;

  logic [BC_W-1:0]   bit_cnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [WORD_W-1:0] shreg_q, sh_next;
  logic [WORD_W-1:0] dly_q;
  logic              tap_q;
  logic              pend_q;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              frame_done_q;
  logic [ADDR_W:0]   frame_len_q;
  logic              overflow_q;
  logic              sdo_q;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (load),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  // One extra flop so sdi lines up with the registered sck edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_sync <= '0;
    end else begin
      sdi_sync <= {sdi_sync[SYNC_STAGES-1:0], sdi};
    end
  end

  assign sdi_s = sdi_sync[SYNC_STAGES];

  always_comb begin
    if (LSB_FIRST != 0) begin
      sh_next = {sdi_s, shreg_q[WORD_W-1:1]};
    end else begin
      sh_next = {shreg_q[WORD_W-2:0], sdi_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A load fall wins over a coincident sck rise: that bit is dropped.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    shift_en  = 1'b0;
    word_end  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_rise || pend_q) begin
          state_d = RECV;
          start   = 1'b1;
        end
      end
      RECV: begin
        if (load_fall) begin
          state_d   = DONE;
          frame_end = 1'b1;
        end else if (sck_rise) begin
          shift_en = 1'b1;
          word_end = (bit_cnt_q == LAST_BIT);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      dly_q        <= '0;
      tap_q        <= 1'b0;
      pend_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      // A load rise during the DONE cycle is remembered and taken from IDLE.
      if (state_q == DONE) begin
        pend_q <= load_rise;
      end else if (start) begin
        pend_q <= 1'b0;
      end

      if (start) begin
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        overflow_q <= 1'b0;
        dly_q      <= '0;
        tap_q      <= 1'b0;
      end

      if (shift_en) begin
        shreg_q <= sh_next;
        dly_q   <= {dly_q[WORD_W-2:0], sdi_s};
        tap_q   <= dly_q[WORD_W-1];
        if (word_end) begin
          bit_cnt_q <= '0;
          if (word_cnt_q < DEPTH_C) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= sh_next;
            wr_addr_q  <= word_cnt_q[ADDR_W-1:0];
            word_cnt_q <= word_cnt_q + 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end

      if (frame_end) begin
        frame_done_q <= 1'b1;
        frame_len_q  <= word_cnt_q;
      end
    end
  end

  // tap_q holds the bit shifted out WORD_W rises ago; it is presented on sck fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_q <= 1'b0;
    end else if (state_q != RECV) begin
      sdo_q <= 1'b0;
    end else if (sck_fall) begin
      sdo_q <= tap_q;
    end
  end

  assign sdo             = sdo_q;
  assign wbus.wr_en      = wr_en_q;
  assign wbus.wr_addr    = wr_addr_q;
  assign wbus.wr_data    = wr_data_q;
  assign wbus.frame_done = frame_done_q;
  assign wbus.frame_len  = frame_len_q;
  assign wbus.overflow   = overflow_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: three configurations (default, LSB-first, DEPTH=4).
module tb_spi_frame_rx;

  localparam int H = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sck, sdi, load, sdo;

  always #5 clk = ~clk;

  spi_frame_rx_if #(.WORD_W(8), .DEPTH(54)) if0 ();
  spi_frame_rx_if #(.WORD_W(8), .DEPTH(54)) if1 ();
  spi_frame_rx_if #(.WORD_W(8), .DEPTH(4))  if2 ();

  spi_frame_rx #(.WORD_W(8), .DEPTH(54), .LSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sck(sck[0]), .sdi(sdi[0]), .load(load[0]), .sdo(sdo[0]), .wbus(if0));
  spi_frame_rx #(.WORD_W(8), .DEPTH(54), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck[1]), .sdi(sdi[1]), .load(load[1]), .sdo(sdo[1]), .wbus(if1));
  spi_frame_rx #(.WORD_W(8), .DEPTH(4), .LSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .sck(sck[2]), .sdi(sdi[2]), .load(load[2]), .sdo(sdo[2]), .wbus(if2));

  // kind 1 = write (a=addr, b=data); kind 2 = frame_done (a=frame_len)
  typedef struct {
    int id;
    int kind;
    int a;
    int b;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] fd_prev = '0;

  function automatic int pack(input int id, input int kind, input int a, input int b);
    return (id << 24) | (kind << 20) | (a << 8) | b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int id, input int kind, input int a, input int b);
    exp_t e;
    e.id = id; e.kind = kind; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic mon(input int id, input logic we, input int a, input int d,
                     input logic fd, input int fl);
    exp_t e;
    if (fd_prev[id]) chk($sformatf("done_width%0d", id), int'(fd), 0);
    fd_prev[id] = fd;
    if (we) begin
      if (sb.size() == 0) begin
        chk($sformatf("unexpected_wr%0d", id), pack(id, 1, a, d), 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("wr%0d", id), pack(id, 1, a, d), pack(e.id, e.kind, e.a, e.b));
      end
    end
    if (fd) begin
      if (sb.size() == 0) begin
        chk($sformatf("unexpected_done%0d", id), pack(id, 2, fl, 0), 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("done%0d", id), pack(id, 2, fl, 0), pack(e.id, e.kind, e.a, e.b));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if0.wr_en, int'(if0.wr_addr), int'(if0.wr_data), if0.frame_done, int'(if0.frame_len));
      mon(1, if1.wr_en, int'(if1.wr_addr), int'(if1.wr_data), if1.frame_done, int'(if1.frame_len));
      mon(2, if2.wr_en, int'(if2.wr_addr), int'(if2.wr_data), if2.frame_done, int'(if2.frame_len));
    end
  end

  task automatic send_bit(input int id, input logic b);
    sdi[id] = b;
    #H;
    sck[id] = 1'b1;
    #H;
    sck[id] = 1'b0;
    #H;
  endtask

  task automatic send_byte(input int id, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(id, v[i]);
  endtask

  task automatic frame_start(input int id);
    load[id] = 1'b1;
    #H;
  endtask

  task automatic frame_stop(input int id);
    load[id] = 1'b0;
    #120;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] stream;
    int          exp_sdo;
    rst_n = 1'b0;
    sck   = '0;
    sdi   = '0;
    load  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_wr_en", int'(if0.wr_en), 0);
    chk("rst_wr_addr", int'(if0.wr_addr), 0);
    chk("rst_wr_data", int'(if0.wr_data), 0);
    chk("rst_frame_done", int'(if0.frame_done), 0);
    chk("rst_frame_len", int'(if0.frame_len), 0);
    chk("rst_overflow", int'(if0.overflow), 0);
    chk("rst_sdo", int'(sdo[0]), 0);

    // Two MSB-first words
    expect_ev(0, 1, 0, 'hA5);
    expect_ev(0, 1, 1, 'h3C);
    expect_ev(0, 2, 2, 0);
    frame_start(0);
    send_byte(0, 8'hA5);
    send_byte(0, 8'h3C);
    frame_stop(0);

    // LSB-first: sequence 1,0,1,0,0,1,0,1 -> 0xA5; 0,1,1,1,1,0,0,0 -> 0x1E
    expect_ev(1, 1, 0, 'hA5);
    expect_ev(1, 1, 1, 'h1E);
    expect_ev(1, 2, 2, 0);
    frame_start(1);
    send_byte(1, 8'b1010_0101);
    send_byte(1, 8'b0111_1000);
    frame_stop(1);

    // Echo: 0x81 then 0x00
    expect_ev(0, 1, 0, 'h81);
    expect_ev(0, 1, 1, 'h00);
    expect_ev(0, 2, 2, 0);
    stream = 16'h8100;
    frame_start(0);
    for (int i = 0; i < 16; i++) begin
      send_bit(0, stream[15-i]);
      exp_sdo = (i < 8) ? 0 : int'(stream[15-(i-8)]);
      chk($sformatf("sdo_fall%0d", i + 1), int'(sdo[0]), exp_sdo);
    end
    frame_stop(0);
    chk("sdo_idle", int'(sdo[0]), 0);

    // Partial trailing word is discarded
    expect_ev(0, 1, 0, 'hFF);
    expect_ev(0, 2, 1, 0);
    frame_start(0);
    send_byte(0, 8'hFF);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    frame_stop(0);

    // DEPTH=4 overflow
    for (int w = 0; w < 4; w++) expect_ev(2, 1, w, (w + 1) * 'h11);
    expect_ev(2, 2, 4, 0);
    frame_start(2);
    for (int w = 0; w < 6; w++) begin
      send_byte(2, 8'((w + 1) * 'h11));
      if (w == 3) chk("ovf_at_depth", int'(if2.overflow), 0);
      if (w == 4) chk("ovf_set", int'(if2.overflow), 1);
    end
    frame_stop(2);
    chk("ovf_hold_idle", int'(if2.overflow), 1);
    expect_ev(2, 2, 0, 0);
    frame_start(2);
    chk("ovf_cleared", int'(if2.overflow), 0);
    frame_stop(2);

    // Reset mid-word after 4 bits
    frame_start(0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(if0.wr_en), 0);
    chk("mid_rst_wr_addr", int'(if0.wr_addr), 0);
    chk("mid_rst_wr_data", int'(if0.wr_data), 0);
    chk("mid_rst_frame_done", int'(if0.frame_done), 0);
    chk("mid_rst_frame_len", int'(if0.frame_len), 0);
    chk("mid_rst_overflow", int'(if0.overflow), 0);
    chk("mid_rst_sdo", int'(sdo[0]), 0);
    load[0] = 1'b0;
    sck[0]  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_ev(0, 1, 0, 'h5A);
    expect_ev(0, 2, 1, 0);
    frame_start(0);
    send_byte(0, 8'h5A);
    frame_stop(0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

SPI-slave frame receiver for the LED-string datapath. It oversamples the host's SPI lines in the `clk` domain and assembles serial bits into `WORD_W`-bit words. Each completed word is written into a frame buffer/SPRAM through a simple write port. It reports frame completion, length and overflow, and echoes a one-word-delayed copy of the input stream on `sdo` for daisy-chaining.

## Interface
- `WORD_W`, 8, bits per word (≥2)
- `DEPTH`, 54, max words per frame (432-bit LED frame at 8 bits)
- `LSB_FIRST`, 0, 0: first bit received is word MSB; 1: first bit is word LSB
- `ADDR_W`, `$clog2(DEPTH)`, write-address width (derived, not overridden)
- `clk`  in  1  system clock; must be ≥4× `sck` frequency
- `rst_n`  in  1  asynchronous, active-low reset
- `sck`  in  1  SPI clock, async to `clk`, CPOL=0/CPHA=0
- `sdi`  in  1  SPI data in, async
- `load`  in  1  frame enable (active-high chip select), async
- `sdo`  out  1  delayed echo of `sdi` stream
- `wr_en`  out  1  one-cycle write strobe
- `wr_addr`  out  ADDR_W  word index within frame
- `wr_data`  out  WORD_W  assembled word
- `frame_done`  out  1  one-cycle pulse at frame end
- `frame_len`  out  ADDR_W+1  words written in last frame (held)
- `overflow`  out  1  sticky: frame exceeded DEPTH words

## Operation
- `sck`, `load` and `sdi` each pass through a 2-flop synchronizer. `sck` and `load` get rise/fall detectors in the `clk` domain.
- FSM states:
  - IDLE: `load` low.
  - RECV: `load` high.
  - DONE: single cycle.
- IDLE→RECV on `load` rise detect. This clears the bit counter, word counter, `overflow` and the echo delay line.
- In RECV, on each `sck` rise detect:
  - If `LSB_FIRST`=0, shift the synced `sdi` into the shift register LSB, left-shifting.
  - If `LSB_FIRST`=1, shift it into the MSB, right-shifting.
  - Then increment the bit counter.
- When the bit counter reaches `WORD_W`:
  - If word count < `DEPTH`: set `wr_en`=1, `wr_data`=word, `wr_addr`=word count; word count +1.
  - Otherwise: no write; set `overflow`=1.
  - The bit counter wraps to 0 in either case.
- RECV→DONE on `load` fall detect. A partial word (bit counter ≠0) is discarded.
- DONE: `frame_done`=1, `frame_len`=word count (saturates at `DEPTH`); then go to IDLE.
- If `load` fall and `sck` rise are detected in the same cycle, the bit is dropped and the frame ends.
- `sdo` is fed by a `WORD_W`-bit delay line of received bits.
  - On each `sck` fall detect in RECV, `sdo` takes the bit received `WORD_W` rising edges earlier. It reads 0 until `WORD_W` bits have arrived.
  - In IDLE, `sdo`=0.
- `load` rise while in DONE is honoured on the next cycle; it is not lost.

## Timing
- Reset values: `sdo`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `frame_len`=0, `overflow`=0. FSM=IDLE.
- Pin-to-detect latency is 3 `clk` cycles: 2 sync flops plus the edge register.
- `wr_en` is registered. It asserts in the cycle after the `sck` rise detect of the `WORD_W`-th bit, for exactly 1 cycle. `wr_addr` and `wr_data` are valid in that cycle.
- `frame_done` asserts 1 cycle after the `load` fall detect. `frame_len` updates in the same cycle and holds until the next DONE.
- `overflow` sets in the cycle the dropped word completes. It holds through IDLE and clears only on the next `load` rise or on reset.
- Reset mid-frame returns all outputs to reset values immediately. No write or `frame_done` is generated.
- `sck` high/low phases must each last ≥2 `clk` periods. Shorter phases are unsupported.

## Structure
- Package `spi_rx_pkg` holds:
  - the `rx_state_t` enum (IDLE, RECV, DONE);
  - `SYNC_STAGES`=2.
- Sub-module `sync_edge`: parametrised `SYNC_STAGES` synchronizer with registered `rise`/`fall` outputs.
  - Instantiated for `sck` and `load`.
  - `sdi` uses the synchronizer only, with matched delay.
- Top level holds the FSM, counters, shift register and echo delay line.

## Test plan
- Defaults, `load` high, send 0xA5 then 0x3C MSB-first, `load` low:
  - writes (0,0xA5) then (1,0x3C);
  - `frame_done` 1 cycle;
  - `frame_len`=2.
- `LSB_FIRST`=1, send bit sequence 1,0,1,0,0,1,0,1: `wr_data`=0xA5 at `wr_addr` 0.
- `DEPTH`=4, send 6 words: exactly 4 writes at addresses 0–3; `overflow`=1; `frame_len`=4. The next `load` rise clears `overflow`.
- Send 0xFF plus 3 extra bits, then `load` low: one write (0xFF); `frame_len`=1; no partial write.
- Send 0x81, then 0x00: `sdo` is 0 for the first 8 falls, then emits 1,0,0,0,0,0,0,1.
- Assert `rst_n` low mid-word after 4 bits: all outputs 0 at once. A new frame after release starts at `wr_addr` 0.
